// File: rtl/lsu_dport.sv
// Load/store unit for the core data-memory port: one request at a time,
// word-aligned beats with byte strobes, word-crossing accesses split in two.
module lsu_dport #(
    parameter logic ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] d_addr,
    output logic [31:0] d_wdata,
    output logic [3:0]  d_wstrb,
    input  logic [31:0] d_rdata
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t      state, state_n;
    logic        we_q, cross_q, err_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [3:0]  m_hi_q;
    logic [31:0] w_hi_q, lo_q, hi_q;

    logic [7:0]  size_m, m8_req;
    logic [63:0] w64_req;
    logic        cross_req, illegal_req, err_req;
    logic [31:0] ld_word;

    // Request decode: lane mask and lane-aligned data over a two-word window.
    always_comb begin
        unique case (req_funct3[1:0])
            2'b00:   size_m = 8'h01;
            2'b01:   size_m = 8'h03;
            default: size_m = 8'h0F;
        endcase
        m8_req      = size_m << req_addr[1:0];
        w64_req     = {32'h0, req_wdata} << {req_addr[1:0], 3'b000};
        cross_req   = |m8_req[7:4];
        illegal_req = (req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11) ||
                      (req_funct3[2] && req_we);
        err_req     = illegal_req || (cross_req && !ALLOW_MISALIGNED);
    end

    always_comb begin
        state_n   = state;
        req_ready = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_n = err_req ? RESP : ACC0;
            end
            ACC0:    state_n = cross_q ? ACC1 : RESP;
            ACC1:    state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            cross_q <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
            m_hi_q  <= '0;
            w_hi_q  <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            d_addr  <= '0;
            d_wdata <= '0;
            d_wstrb <= '0;
        end else begin
            state <= state_n;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        off_q   <= req_addr[1:0];
                        cross_q <= cross_req;
                        err_q   <= err_req;
                        m_hi_q  <= m8_req[7:4];
                        w_hi_q  <= w64_req[63:32];
                        if (!err_req) begin
                            d_addr  <= {req_addr[31:2], 2'b00};
                            d_wstrb <= req_we ? m8_req[3:0] : '0;
                            d_wdata <= w64_req[31:0];
                        end
                    end
                end
                ACC0: begin
                    lo_q <= d_rdata;
                    hi_q <= '0;
                    if (cross_q) begin
                        d_addr  <= d_addr + 32'd4;
                        d_wstrb <= we_q ? m_hi_q : '0;
                        d_wdata <= w_hi_q;
                    end else begin
                        d_wstrb <= '0;
                    end
                end
                ACC1: begin
                    hi_q    <= d_rdata;
                    d_wstrb <= '0;
                end
                default: ;
            endcase
        end
    end

    assign ld_word = 32'({hi_q, lo_q} >> {off_q, 3'b000});

    always_comb begin
        rsp_valid = (state == RESP);
        rsp_err   = rsp_valid && err_q;
        rsp_rdata = '0;
        if (rsp_valid && !err_q && !we_q) begin
            unique case (f3_q)
                3'd0:    rsp_rdata = {{24{ld_word[7]}}, ld_word[7:0]};
                3'd1:    rsp_rdata = {{16{ld_word[15]}}, ld_word[15:0]};
                3'd2:    rsp_rdata = ld_word;
                3'd4:    rsp_rdata = {24'h0, ld_word[7:0]};
                3'd5:    rsp_rdata = {16'h0, ld_word[15:0]};
                default: rsp_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_dport.sv
// Directed bench for lsu_dport: byte-level reference model predicts every busy
// cycle (beats, strobes, response); literal expectations pin the model.
module tb_lsu_dport;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata, d_addr, d_wdata, d_rdata;
    logic [3:0]  d_wstrb;

    logic        nm_valid = 1'b0;
    logic        nm_ready, nm_rsp_valid, nm_rsp_err;
    logic [31:0] nm_rsp_rdata, nm_d_addr, nm_d_wdata, nm_rdata;
    logic [3:0]  nm_d_wstrb;

    always #5 clk = ~clk;

    lsu_dport dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_rdata(d_rdata)
    );

    lsu_dport #(.ALLOW_MISALIGNED(1'b0)) dut_nm (
        .clk(clk), .rst(rst), .req_valid(nm_valid), .req_ready(nm_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(nm_rsp_valid), .rsp_rdata(nm_rsp_rdata),
        .rsp_err(nm_rsp_err), .d_addr(nm_d_addr), .d_wdata(nm_d_wdata),
        .d_wstrb(nm_d_wstrb), .d_rdata(nm_rdata)
    );

    assign nm_rdata = 32'h8899AABB;

    // Responder memory (32 words, aliased by d_addr[6:2]) and model shadow copy.
    logic [31:0] dmem [32];
    logic [31:0] rmem [32];
    assign d_rdata = dmem[d_addr[6:2]];
    always @(posedge clk)
        for (int j = 0; j < 4; j++)
            if (d_wstrb[j]) dmem[d_addr[6:2]][8*j +: 8] <= d_wdata[8*j +: 8];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          beat;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        bit          rsp;
        bit          err;
        logic [31:0] rdata;
    } cyc_t;

    cyc_t        expq[$];
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;

    always @(negedge clk) begin
        cyc_t c;
        if (expq.size() == 0) begin
            chk("idle_ready", 32'(req_ready), 1);
            chk("idle_rsp_valid", 32'(rsp_valid), 0);
            chk("idle_wstrb", 32'(d_wstrb), 0);
        end else begin
            c = expq.pop_front();
            chk("busy_ready", 32'(req_ready), 0);
            if (c.beat) begin
                chk("beat_addr", d_addr, c.addr);
                chk("beat_wstrb", 32'(d_wstrb), 32'(c.strb));
                if (c.strb != 0) chk("beat_wdata", d_wdata, c.wdata);
                for (int j = 0; j < 4; j++)
                    if (c.strb[j]) rmem[c.addr[6:2]][8*j +: 8] = c.wdata[8*j +: 8];
            end else begin
                chk("nobeat_wstrb", 32'(d_wstrb), 0);
            end
            chk("rsp_valid", 32'(rsp_valid), 32'(c.rsp));
            if (c.rsp) begin
                chk("rsp_err", 32'(rsp_err), 32'(c.err));
                chk("rsp_rdata", rsp_rdata, c.rdata);
                last_rdata = rsp_rdata;
                last_err   = rsp_err;
            end
        end
    end

    // Reference: walk the accessed bytes one at a time, assign each to the
    // first or second word, and assemble the load value from the shadow memory.
    task automatic model(input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        cyc_t        b0, b1, r;
        int          n;
        int          k;
        bit          two;
        logic [31:0] ba, val;
        b0 = '{default: 0};
        b1 = '{default: 0};
        r  = '{default: 0};
        r.rsp = 1;
        if (!(f3 == 0 || f3 == 1 || f3 == 2 || ((f3 == 4 || f3 == 5) && !we))) begin
            r.err = 1;
            expq.push_back(r);
            return;
        end
        n = 1 << f3[1:0];
        b0.beat = 1; b0.addr = {a[31:2], 2'b00};
        b1.beat = 1; b1.addr = b0.addr + 32'd4;
        val = '0;
        two = 0;
        for (int i = 0; i < n; i++) begin
            ba = a + 32'(i);
            k  = (ba[31:2] == a[31:2]) ? 0 : 1;
            if (k == 1) two = 1;
            if (we) begin
                if (k == 0) begin
                    b0.strb[ba[1:0]] = 1'b1;
                    b0.wdata[8*ba[1:0] +: 8] = wd[8*i +: 8];
                end else begin
                    b1.strb[ba[1:0]] = 1'b1;
                    b1.wdata[8*ba[1:0] +: 8] = wd[8*i +: 8];
                end
            end
            val[8*i +: 8] = rmem[ba[6:2]][8*ba[1:0] +: 8];
        end
        if (f3 == 0) val = {{24{val[7]}}, val[7:0]};
        if (f3 == 1) val = {{16{val[15]}}, val[15:0]};
        r.rdata = we ? 32'h0 : val;
        expq.push_back(b0);
        if (two) expq.push_back(b1);
        expq.push_back(r);
    endtask

    task automatic issue(input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        model(we, f3, a, wd);
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
        int k;
        issue(we, f3, a, wd);
        k = 0;
        while (expq.size() != 0 && k < 10) begin
            @(posedge clk);
            k++;
        end
        if (expq.size() != 0) begin
            chk("req_timeout", 32'(expq.size()), 0);
            expq.delete();
        end
        #1;
    endtask

    task automatic nm_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic exp_err, input logic [31:0] exp_rdata, input int exp_lat);
        int k;
        bit seen;
        chk("nm_ready", 32'(nm_ready), 1);
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = '0;
        nm_valid = 1'b1;
        @(posedge clk);
        #1 nm_valid = 1'b0;
        k = 0;
        seen = 0;
        while (!seen && k < 8) begin
            @(negedge clk);
            k++;
            chk("nm_wstrb", 32'(nm_d_wstrb), 0);
            if (k == 1 && !exp_err) begin
                chk("nm_addr", nm_d_addr, {a[31:2], 2'b00});
                chk("nm_wdata", nm_d_wdata, 0);
            end
            if (nm_rsp_valid) seen = 1;
        end
        chk("nm_rsp_seen", 32'(seen), 1);
        chk("nm_latency", k, exp_lat);
        chk("nm_err", 32'(nm_rsp_err), 32'(exp_err));
        chk("nm_rdata", nm_rsp_rdata, exp_rdata);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals();
        chk("rst_ready", 32'(req_ready), 1);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_d_addr", d_addr, 0);
        chk("rst_d_wdata", d_wdata, 0);
        chk("rst_d_wstrb", 32'(d_wstrb), 0);
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        dmem[a[6:2]] <= v;
        rmem[a[6:2]] = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) preload(32'(i * 4), 32'h0);
        preload(32'h40, 32'h8899AABB);
        preload(32'hFFFFFFFC, 32'h7F000000);
        preload(32'h0, 32'h00000080);
        @(posedge clk);
        #1 chk_reset_vals();
        @(posedge clk);
        #1 rst = 1'b0;

        do_req(0, 3'd2, 32'h40, 32'h0);
        chk("lw_40", last_rdata, 32'h8899AABB);
        do_req(0, 3'd0, 32'h43, 32'h0);
        chk("lb_43", last_rdata, 32'hFFFFFF88);
        do_req(0, 3'd4, 32'h43, 32'h0);
        chk("lbu_43", last_rdata, 32'h00000088);
        do_req(1, 3'd0, 32'h43, 32'h000000A5);
        chk("sb_err", 32'(last_err), 0);
        chk("sb_mem40", dmem[16], 32'hA599AABB);

        do_req(1, 3'd2, 32'h41, 32'h11223344);
        chk("sw41_mem40", dmem[16], 32'h223344BB);
        chk("sw41_mem44", dmem[17], 32'h00000011);
        do_req(0, 3'd2, 32'h42, 32'h0);
        chk("lw_42", last_rdata, 32'h00112233);
        do_req(0, 3'd1, 32'h41, 32'h0);
        chk("lh_41", last_rdata, 32'h00003344);

        do_req(0, 3'd1, 32'hFFFFFFFF, 32'h0);
        chk("lh_wrap", last_rdata, 32'hFFFF807F);
        do_req(0, 3'd5, 32'hFFFFFFFF, 32'h0);
        chk("lhu_wrap", last_rdata, 32'h0000807F);
        do_req(1, 3'd1, 32'hFFFFFFFF, 32'h0000BEEF);
        chk("sh_wrap_hi", dmem[31], 32'hEF000000);
        chk("sh_wrap_lo", dmem[0], 32'h000000BE);

        do_req(1, 3'd4, 32'h40, 32'hFFFFFFFF);
        chk("sbu_err", 32'(last_err), 1);
        chk("sbu_mem40", dmem[16], 32'h223344BB);
        do_req(0, 3'd3, 32'h40, 32'h0);
        chk("f3_3_err", 32'(last_err), 1);
        do_req(0, 3'd6, 32'h40, 32'h0);
        chk("f3_6_err", 32'(last_err), 1);

        nm_req(0, 3'd2, 32'h42, 1'b1, 32'h0, 1);
        nm_req(1, 3'd2, 32'h41, 1'b1, 32'h0, 1);
        nm_req(0, 3'd2, 32'h40, 1'b0, 32'h8899AABB, 2);
        nm_req(0, 3'd1, 32'h41, 1'b0, 32'hFFFF99AA, 2);
        nm_req(1, 3'd5, 32'h40, 1'b1, 32'h0, 1);

        // Reset lands in ACC1: first beat already committed, second never issued.
        issue(1, 3'd2, 32'h43, 32'hCAFEF00D);
        @(posedge clk);
        #1 rst = 1'b1;
        expq.delete();
        #1 chk_reset_vals();
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_ready_after", 32'(req_ready), 1);
        chk("rst_mem40", dmem[16], 32'h0D3344BB);
        chk("rst_mem44", dmem[17], 32'h00000011);

        do_req(0, 3'd2, 32'h40, 32'h0);
        chk("lw_after_rst", last_rdata, 32'h0D3344BB);

        for (int i = 0; i < 32; i++) chk("mem_sweep", dmem[i], rmem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
